// File: rtl/lsu_defs.sv
// Shared definitions for the load/store unit: funct3 codes,
// FSM state encoding and the request legality check.
package lsu_defs;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACCESS   = 2'd1,
        S_MERGE_WR = 2'd2,
        S_RESP     = 2'd3
    } lsu_state_t;

    // Unsigned variants exist only for loads.
    function automatic logic req_legal(
        input logic       write,
        input logic [2:0] funct3,
        input logic [1:0] offset
    );
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = !offset[0];
            F3_W:    ok = (offset == 2'b00);
            F3_BU:   ok = !write;
            F3_HU:   ok = !write && !offset[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store merge into an old word
// and load extract with sign/zero extension.
module lsu_align
    import lsu_defs::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] old_word,
    input  logic [15:0] wdata,
    input  logic [31:0] rd,
    output logic [31:0] merged,
    output logic [31:0] extracted
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    assign rd_byte = rd[{offset, 3'b000} +: 8];
    assign rd_half = offset[1] ? rd[31:16] : rd[15:0];

    always_comb begin
        merged = old_word;
        if (funct3 == F3_H) begin
            if (offset[1]) merged[31:16] = wdata;
            else           merged[15:0]  = wdata;
        end else begin
            merged[{offset, 3'b000} +: 8] = wdata[7:0];
        end
    end

    always_comb begin
        extracted = rd;
        case (funct3)
            F3_B:    extracted = {{24{rd_byte[7]}}, rd_byte};
            F3_BU:   extracted = {24'd0, rd_byte};
            F3_H:    extracted = {{16{rd_half[15]}}, rd_half};
            F3_HU:   extracted = {16'd0, rd_half};
            default: extracted = rd;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: byte requests to word accesses,
// read-modify-write for sub-word stores, load extension.
module load_store_unit
    import lsu_defs::*;
#(
    parameter  int memory_width = 32,
    parameter  int memory_depth = 1024,
    localparam int AW           = $clog2(memory_depth)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    req_valid,
    input  logic                    req_write,
    input  logic [2:0]              req_funct3,
    input  logic [31:0]             req_addr,
    input  logic [31:0]             req_wdata,
    output logic                    busy,
    output logic                    rsp_valid,
    output logic [31:0]             rsp_rdata,
    output logic                    rsp_err,
    output logic                    mem_re,
    output logic                    mem_we,
    output logic [AW-1:0]           mem_a,
    output logic [memory_width-1:0] mem_wd,
    input  logic [memory_width-1:0] mem_rd,
    input  logic                    mem_stall
);

    lsu_state_t  state_q;
    lsu_state_t  state_d;
    logic        write_q;
    logic [2:0]  f3_q;
    logic [AW+1:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept;
    logic        legal;
    logic        is_sw;
    logic        is_sub;
    logic [31:0] merged;
    logic [31:0] extracted;
    logic        unused_addr;

    assign unused_addr = ^req_addr[31:AW+2];

    assign accept = req_valid && !busy;
    assign legal  = req_legal(req_write, req_funct3, req_addr[1:0]);
    assign is_sw  = write_q && (f3_q == F3_W);
    assign is_sub = write_q && (f3_q != F3_W);

    lsu_align u_align (
        .funct3    (f3_q),
        .offset    (addr_q[1:0]),
        .old_word  (word_q),
        .wdata     (wdata_q[15:0]),
        .rd        (mem_rd),
        .merged    (merged),
        .extracted (extracted)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (accept) state_d = legal ? S_ACCESS : S_RESP;
                else        state_d = S_IDLE;
            end
            S_ACCESS: begin
                if (!mem_stall) state_d = is_sub ? S_MERGE_WR : S_RESP;
            end
            S_MERGE_WR: begin
                if (!mem_stall) state_d = S_RESP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Bus signals decode only registered state, so they hold through stalls.
    always_comb begin
        busy      = (state_q == S_ACCESS) || (state_q == S_MERGE_WR);
        rsp_valid = (state_q == S_RESP);
        rsp_err   = rsp_valid && err_q;
        rsp_rdata = rdata_q;
        mem_a     = addr_q[AW+1:2];
        mem_re    = (state_q == S_ACCESS) && !is_sw;
        mem_we    = ((state_q == S_ACCESS) && is_sw) ||
                    (state_q == S_MERGE_WR);
        mem_wd    = '0;
        if (state_q == S_MERGE_WR)           mem_wd = merged;
        else if ((state_q == S_ACCESS) && is_sw) mem_wd = wdata_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            word_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q <= req_write;
                f3_q    <= req_funct3;
                addr_q  <= req_addr[AW+1:0];
                wdata_q <= req_wdata;
                err_q   <= !legal;
                rdata_q <= '0;
            end
            if ((state_q == S_ACCESS) && !mem_stall) begin
                word_q <= mem_rd;
                if (!write_q) rdata_q <= extracted;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit with a byte-level memory
// model, latency accounting and directed corner cases.
module tb_load_store_unit;
    import lsu_defs::*;

    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_write;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          busy;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          mem_re;
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [31:0]   mem_wd;
    logic [31:0]   mem_rd;
    logic          mem_stall = 1'b0;

    load_store_unit #(
        .memory_width (32),
        .memory_depth (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .busy       (busy),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .mem_a      (mem_a),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd),
        .mem_stall  (mem_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        logic [31:0] rdata;
        int          acc;
        int          st0;
        int          base;
    } exp_t;

    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    exp_t        q[$];
    exp_t        cur;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          stall_cnt = 0;
    int          stall_left = 0;
    bit          rand_stall = 0;
    int          acc_last = 0;
    bit          acc_in_resp = 0;
    bit          hold = 0;
    logic [37:0] snap = '0;

    assign mem_rd = mem[mem_a];

    // Memory system stand-in: whole-word write when not stalled.
    always @(posedge clk) begin
        if (reset_n && mem_we && !mem_stall) mem[mem_a] = mem_wd;
    end

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        stall_cnt <= stall_cnt + ((busy && mem_stall) ? 1 : 0);
        hold      <= reset_n && busy && mem_stall;
        snap      <= {mem_re, mem_we, mem_a, mem_wd};
    end

    always @(negedge clk) begin
        if (rand_stall) begin
            mem_stall = busy && ($urandom_range(0, 2) == 0);
        end else if (stall_left > 0 && busy) begin
            mem_stall  = 1'b1;
            stall_left = stall_left - 1;
        end else begin
            mem_stall = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic poke(input int idx, input logic [31:0] v);
        mem[idx]     = v;
        ref_mem[idx] = v;
    endtask

    // Reference: byte-addressed memory of DEPTH*4 bytes.
    function automatic void model(input bit wr, input logic [2:0] f3,
                                  input logic [31:0] a,
                                  input logic [31:0] wd,
                                  output bit err,
                                  output logic [31:0] rd);
        int size, idx, off;
        bit uns;
        logic [31:0] w, mask, v;
        case (f3[1:0])
            2'd0:    size = 1;
            2'd1:    size = 2;
            2'd2:    size = 4;
            default: size = 0;
        endcase
        uns = f3[2];
        off = int'(a % 4);
        idx = int'((a / 4) % DEPTH);
        if (size == 0) err = 1;
        else err = (uns && (wr || size == 4)) || (off % size != 0);
        rd = '0;
        if (err) return;
        w = ref_mem[idx];
        if (wr) begin
            for (int i = 0; i < size; i++)
                w[8*(off+i) +: 8] = wd[8*i +: 8];
            ref_mem[idx] = w;
        end else begin
            mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*size)) - 1);
            v = (w >> (8*off)) & mask;
            if (!uns && size < 4 && v[8*size-1]) v = v | ~mask;
            rd = v;
        end
    endfunction

    task automatic issue(input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: busy stuck high at cycle %0d", cyc);
            return;
        end
        acc_in_resp = rsp_valid;
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        model(wr, f3, a, wd, e.err, e.rdata);
        e.acc  = cyc;
        e.st0  = stall_cnt;
        e.base = e.err ? 1 : ((wr && f3[1:0] != 2'd2) ? 3 : 2);
        q.push_back(e);
        acc_last = cyc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [31:0] d, output bit e,
                            output int lat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 100);
        if (!rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: no rsp_valid within 100 cycles");
        end
        d   = rsp_rdata;
        e   = rsp_err;
        lat = cyc - acc_last;
    endtask

    // Continuous checker against the reference queue and bus rules.
    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_re && mem_we) chk("re_we_overlap", 32'(mem_re & mem_we), 0);
            if (hold) chk("stall_stable", snap[31:0], mem_wd);
            if (hold) chk("stall_stable_ctl",
                          {26'd0, snap[37:32]}, {26'd0, mem_re, mem_we, mem_a});
            if (q.size() > 0 && q[0].err)
                chk("err_no_access", 32'(mem_re | mem_we), 0);
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid), 0);
                end else begin
                    cur = q.pop_front();
                    chk("rsp_rdata", rsp_rdata, cur.rdata);
                    chk("rsp_err", 32'(rsp_err), 32'(cur.err));
                    chk("latency", cyc,
                        cur.acc + cur.base + (stall_cnt - cur.st0));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        bit          e;
        int          lat;
        logic [31:0] saved;
        int          n;

        reset_n    = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        for (int i = 0; i < DEPTH; i++) poke(i, $urandom);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_mem_re", 32'(mem_re), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_a", 32'(mem_a), 0);
        chk("rst_mem_wd", mem_wd, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // LW hit
        poke(4, 32'hDEAD_BEEF);
        issue(0, F3_W, 32'h0000_0010, 0);
        @(negedge clk);
        chk("lw_mem_re_c1", 32'(mem_re), 1);
        chk("lw_mem_a", 32'(mem_a), 4);
        wait_rsp(d, e, lat);
        chk("lw_latency", lat, 2);
        chk("lw_rdata", d, 32'hDEAD_BEEF);

        // LB / LBU / LH
        poke(4, 32'h8012_3456);
        issue(0, F3_B, 32'h13, 0);
        wait_rsp(d, e, lat);
        chk("lb_rdata", d, 32'hFFFF_FF80);
        issue(0, F3_BU, 32'h13, 0);
        wait_rsp(d, e, lat);
        chk("lbu_rdata", d, 32'h0000_0080);
        issue(0, F3_H, 32'h12, 0);
        wait_rsp(d, e, lat);
        chk("lh_rdata", d, 32'hFFFF_8012);

        // SB with a 3-cycle stall on the read
        poke(8, 32'h1122_3344);
        stall_left = 3;
        issue(1, F3_B, 32'h21, 32'hAA);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            chk("sb_busy_stall", 32'(busy), 1);
        end
        @(negedge clk);
        chk("sb_merge_we", 32'(mem_we), 1);
        chk("sb_merge_re", 32'(mem_re), 0);
        chk("sb_merge_wd", mem_wd, 32'h1122_AA44);
        wait_rsp(d, e, lat);
        chk("sb_latency", lat, 6);
        chk("sb_mem_word", mem[8], 32'h1122_AA44);

        // Misaligned and illegal
        issue(0, F3_W, 32'h02, 0);
        wait_rsp(d, e, lat);
        chk("lw_mis_err", 32'(e), 1);
        chk("lw_mis_lat", lat, 1);
        issue(1, F3_H, 32'h05, 32'h1234);
        wait_rsp(d, e, lat);
        chk("sh_mis_err", 32'(e), 1);
        chk("sh_mis_lat", lat, 1);
        issue(1, F3_BU, 32'h08, 32'h77);
        wait_rsp(d, e, lat);
        chk("st_f3_100_err", 32'(e), 1);

        // Back-to-back: SW accepted in a load's RESP cycle, then LW
        issue(0, F3_W, 32'h10, 0);
        issue(1, F3_W, 32'h40, 32'h5);
        chk("b2b_sw_in_resp", 32'(acc_in_resp), 1);
        issue(0, F3_W, 32'h40, 0);
        chk("b2b_lw_in_resp", 32'(acc_in_resp), 1);
        wait_rsp(d, e, lat);
        chk("b2b_lw_rdata", d, 32'h5);

        // Randomized traffic with random stalls
        rand_stall = 1;
        for (int i = 0; i < 300; i++) begin
            bit          wr;
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] wd;
            wr = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            wd = $urandom;
            issue(wr, f3, a, wd);
        end
        n = 0;
        while (q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue", q.size(), 0);
        rand_stall = 0;
        @(negedge clk);

        // Reset while the SH write-back is pending
        poke(12, 32'hCAFE_F00D);
        saved = ref_mem[12];
        issue(1, F3_H, 32'h32, 32'h1234);
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_we_before", 32'(mem_we), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_we", 32'(mem_we), 0);
        chk("rst_mid_re", 32'(mem_re), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_mid_mem_a", 32'(mem_a), 0);
        chk("rst_mid_mem_wd", mem_wd, 0);
        q.delete();
        ref_mem[12] = saved;
        @(posedge clk);
        #1;
        chk("rst_mid_no_write", mem[12], 32'hCAFE_F00D);
        @(negedge clk);
        reset_n = 1'b1;
        issue(0, F3_W, 32'h30, 0);
        wait_rsp(d, e, lat);
        chk("rst_recover_rdata", d, 32'hCAFE_F00D);

        for (int i = 0; i < DEPTH; i++)
            chk("final_mem", mem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit of the RISC-V core; sits directly upstream of `memory_system`, driving its `RE`/`WE`/`A`/`WD` and consuming its `RD`/`stall`.

- Converts a core byte-addressed request into word accesses.
- Performs read-modify-write for SB/SH, because `memory_system` only writes whole words.
- Sign- or zero-extends load data.
- Raises a stall to the pipeline until the access completes.

## Interface
Parameters:
- `memory_width`, 32: data word width; must match `memory_system`.
- `memory_depth`, 1024: words in `memory_system`. `AW = $clog2(memory_depth)`.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: core presents a memory op this cycle.
- `req_write`  in  1: 1 = store, 0 = load.
- `req_funct3`  in  3: RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `req_addr`  in  32: byte address.
- `req_wdata`  in  32: store data, right-aligned.
- `busy`  out  1: pipeline stall; a request is accepted only when `busy` = 0.
- `rsp_valid`  out  1: one-cycle pulse, op finished.
- `rsp_rdata`  out  32: extended load data; 0 for stores and errors.
- `rsp_err`  out  1: misaligned address or illegal funct3, qualified by `rsp_valid`.
- `mem_re`, `mem_we`  out  1: to `memory_system` `RE`, `WE`.
- `mem_a`  out  AW: word index, `req_addr[AW+1:2]`.
- `mem_wd`  out  32: to `WD`.
- `mem_rd`  in  32: from `RD`.
- `mem_stall`  in  1: from `stall`.

## Operation
- **Accept:** `req_valid && !busy` registers `write`, `funct3`, `addr`, `wdata`.
- **Legality check, at accept:**
  - Loads: funct3 ∈ {000,001,010,100,101}.
  - Stores: funct3 ∈ {000,001,010}.
  - Alignment: H/HU requires `addr[0]` = 0; W requires `addr[1:0]` = 0.
  - An illegal or misaligned request goes to RESP with `rsp_err` = 1 and makes no memory access.
- **FSM states:** IDLE, ACCESS, MERGE_WR, RESP.
  - IDLE → ACCESS on a legal accept; IDLE → RESP on an error accept.
  - ACCESS:
    - Loads and SB/SH drive `mem_re` = 1.
    - SW drives `mem_we` = 1 with `mem_wd` = wdata.
    - The state holds while `mem_stall` = 1.
    - The access completes on the first ACCESS cycle with `mem_stall` = 0; `mem_rd` is sampled in that cycle.
    - Completion of a load or SW → RESP. Completion of SB/SH → MERGE_WR, with the read word latched.
  - MERGE_WR:
    - `mem_we` = 1; `mem_wd` = latched word with the byte `addr[1:0]` or halfword `addr[1]` replaced by `wdata[7:0]` / `wdata[15:0]`.
    - Holds while `mem_stall` = 1, then → RESP.
  - RESP:
    - `rsp_valid` = 1 and `busy` = 0, so a new request may be accepted in this cycle: legal → ACCESS, error → RESP, none → IDLE.
- **Busy and bus stability:**
  - `busy` = 1 in ACCESS and MERGE_WR only.
  - `mem_a`, `mem_wd`, `mem_re`, `mem_we` come from registered state and stay stable across stall cycles.
  - `mem_re` and `mem_we` are never both 1.
- **Load extract:** select the byte/halfword by `addr[1:0]`.
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - `rsp_rdata` is registered at ACCESS completion.
- **Address range:** `req_addr` bits above AW+1 are ignored, so addresses wrap modulo `4*memory_depth`.

## Timing
- **Reset values:** every output 0; state IDLE; request registers 0.
- **Reset mid-operation:** an asynchronous assert returns the FSM to IDLE and drops `mem_re`/`mem_we` immediately. A pending RMW is abandoned; the write is not issued.
- **Latency,** counting the accept cycle as 0, with N = stall cycles:
  - Load or SW, hit: ACCESS at 1, `rsp_valid` at 2; N stall cycles add N.
  - SB/SH: ACCESS at 1, MERGE_WR at 2, `rsp_valid` at 3, plus stalls in either access state.
  - Error: `rsp_valid` at 1.
- **Back-to-back:** a request accepted in RESP starts ACCESS the next cycle. Throughput is one load per 2 cycles on hits.

## Structure
- Shared package/header `lsu_defs`:
  - funct3 constants: `F3_B`=000, `F3_H`=001, `F3_W`=010, `F3_BU`=100, `F3_HU`=101.
  - State encoding.
- Sub-module `lsu_align`: purely combinational store merge and load extract/extend, driven by funct3 and `addr[1:0]`. The FSM and registers stay in the top module.

## Test plan
- **LW hit:** `addr` 0x0000_0010, `mem_rd` 0xDEAD_BEEF, no stall.
  - `mem_a` = 4, `mem_re` at cycle 1, `rsp_valid` at 2, `rsp_rdata` = 0xDEAD_BEEF.
- **LB / LBU:** `addr` 0x13, word 0x80_12_34_56.
  - LB → 0xFFFF_FF80; LBU → 0x0000_0080.
  - LH at 0x12 → 0xFFFF_8012.
- **SB with a 3-cycle miss stall on the read:** `addr` 0x21, `wdata` 0xAA, old word 0x1122_3344.
  - `busy` stays high through the stall.
  - MERGE_WR drives `mem_we` with `mem_wd` = 0x1122_AA44.
  - `rsp_valid` at cycle 6.
- **Misaligned and illegal:**
  - LW at 0x02 and SH at 0x05 → `rsp_valid` at 1, `rsp_err` = 1, no `mem_re`/`mem_we` ever asserted.
  - Store with funct3 = 100 → `rsp_err` = 1.
- **Back-to-back:** SW 0x40 = 0x5 accepted in the RESP cycle of a prior load, then LW 0x40.
  - Returns 0x5; `mem_re`/`mem_we` never overlap.
- **Reset in MERGE_WR:** assert `reset_n` = 0 mid-SH.
  - `mem_we` falls the same cycle, all outputs 0, FSM in IDLE.
